traffic_light_monitor: RTL

Passive observer on the far end of the lamp interface. Samples the controller's `red`/`green`/`yellow` lamp outputs and decodes them back into a phase. Checks one-hot encoding, phase order (red → green → yellow → red) and dwell time per phase against the configured durations. Reports phase, completed sequences and error events, for use as an in-system checker and as the bench scoreboard for the lamp controller.

---
 rtl/traffic_light_pkg.sv | 33 +++
 rtl/traffic_lamp_decoder.sv | 29 ++
 rtl/traffic_light_monitor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: definitions shared by the lamp controller and the lamp monitor.
//   phase_e      : lamp phase encoding (00 red, 01 green, 10 yellow)
//   DEF_*_CYCLES : default dwell per phase, in clock samples
//   err_code_e   : monitor error codes (00 none, 01 one-hot, 10 order, 11 dwell)
//   next_phase() : legal successor of a phase (red -> green -> yellow -> red)
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PH_RED    = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10
  } phase_e;

  localparam int DEF_RED_CYCLES    = 5;
  localparam int DEF_GREEN_CYCLES  = 5;
  localparam int DEF_YELLOW_CYCLES = 2;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_ONEHOT = 2'b01,
    ERR_ORDER  = 2'b10,
    ERR_DWELL  = 2'b11
  } err_code_e;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_RED:   next_phase = PH_GREEN;
      PH_GREEN: next_phase = PH_YELLOW;
      default:  next_phase = PH_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_lamp_decoder.sv
// traffic_lamp_decoder: combinational decode of the three lamp lines.
//   red, green, yellow : observed lamps
//   valid              : exactly one lamp is lit
//   phase              : phase of the lit lamp (PH_RED when not valid)
//   onehot_err         : zero lamps or more than one lamp lit
module traffic_lamp_decoder
  import traffic_light_pkg::*;
(
  input  logic   red,
  input  logic   green,
  input  logic   yellow,
  output logic   valid,
  output phase_e phase,
  output logic   onehot_err
);

  always_comb begin
    valid = 1'b0;
    phase = PH_RED;
    case ({red, green, yellow})
      3'b100: begin valid = 1'b1; phase = PH_RED;    end
      3'b010: begin valid = 1'b1; phase = PH_GREEN;  end
      3'b001: begin valid = 1'b1; phase = PH_YELLOW; end
      default: ;
    endcase
    onehot_err = ~valid;
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker of the red/green/yellow lamp outputs.
// Locks onto a red onset, then checks one-hot encoding, phase order and the
// dwell of each phase. All outputs are registered (1-cycle latency).
//   clk, rst          : clock, synchronous active-high reset
//   red_i/green_i/yellow_i : observed lamps
//   phase_o           : tracked phase (00 when unlocked)
//   phase_valid_o     : monitor locked
//   err_pulse_o       : one-cycle pulse per error
//   err_sticky_o      : any error since reset
//   err_code_o        : code of first error since reset
//   cycle_done_o      : pulse on each legal yellow->red
//   cycle_count_o     : completed sequences, wrapping
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red_i,
  input  logic       green_i,
  input  logic       yellow_i,
  output logic [1:0] phase_o,
  output logic       phase_valid_o,
  output logic       err_pulse_o,
  output logic       err_sticky_o,
  output logic [1:0] err_code_o,
  output logic       cycle_done_o,
  output logic [7:0] cycle_count_o
);

  typedef enum logic [1:0] {ST_SYNC, ST_RED, ST_GREEN, ST_YELLOW} state_e;

  state_e           state, nxt;
  logic [CNT_W-1:0] dwell, nxt_dwell, dwell_sat;
  logic [CNT_W:0]   dwell_p1, dur;
  logic             fresh, prev_red;

  logic             lamp_valid, onehot_err;
  phase_e           lamp, cur_ph, succ_ph;
  logic             err, done;
  err_code_e        err_code;
  logic [1:0]       nxt_ph;

  traffic_lamp_decoder u_dec (
    .red       (red_i),
    .green     (green_i),
    .yellow    (yellow_i),
    .valid     (lamp_valid),
    .phase     (lamp),
    .onehot_err(onehot_err)
  );

  function automatic state_e ph_to_st(input phase_e p);
    case (p)
      PH_RED:   ph_to_st = ST_RED;
      PH_GREEN: ph_to_st = ST_GREEN;
      default:  ph_to_st = ST_YELLOW;
    endcase
  endfunction

  // Expected lamp and its required dwell for the current locked state.
  always_comb begin
    cur_ph = PH_RED;
    dur    = (CNT_W+1)'(RED_CYCLES);
    case (state)
      ST_GREEN:  begin cur_ph = PH_GREEN;  dur = (CNT_W+1)'(GREEN_CYCLES);  end
      ST_YELLOW: begin cur_ph = PH_YELLOW; dur = (CNT_W+1)'(YELLOW_CYCLES); end
      default: ;
    endcase
    succ_ph = next_phase(cur_ph);
  end

  // One extra bit so dwell+1 cannot wrap before the overrun compare.
  assign dwell_p1  = {1'b0, dwell} + (CNT_W+1)'(1);
  assign dwell_sat = (&dwell) ? dwell : dwell + 1'b1;

  // Next-state / check decision; the checks are mutually exclusive by
  // priority, so at most one error is raised per sample.
  always_comb begin
    err       = 1'b0;
    err_code  = ERR_NONE;
    nxt       = state;
    nxt_dwell = dwell;
    done      = 1'b0;
    if (onehot_err) begin
      err      = 1'b1;
      err_code = ERR_ONEHOT;
    end else if (state == ST_SYNC) begin
      // Only a genuine red onset locks; a red held over from an error
      // sample (prev_red=1) does not.
      if (lamp == PH_RED && (fresh || !prev_red)) begin
        nxt       = ST_RED;
        nxt_dwell = CNT_W'(1);
      end
    end else if (lamp == cur_ph) begin
      if (dwell_p1 > dur) begin
        err      = 1'b1;
        err_code = ERR_DWELL;
      end else begin
        nxt_dwell = dwell_sat;
      end
    end else if (lamp == succ_ph) begin
      if ({1'b0, dwell} != dur) begin
        err      = 1'b1;
        err_code = ERR_DWELL;
      end else begin
        nxt       = ph_to_st(succ_ph);
        nxt_dwell = CNT_W'(1);
        done      = (state == ST_YELLOW);
      end
    end else begin
      err      = 1'b1;
      err_code = ERR_ORDER;
    end
    if (err) begin
      nxt       = ST_SYNC;
      nxt_dwell = '0;
    end
  end

  always_comb begin
    case (nxt)
      ST_GREEN:  nxt_ph = PH_GREEN;
      ST_YELLOW: nxt_ph = PH_YELLOW;
      default:   nxt_ph = PH_RED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_SYNC;
      dwell         <= '0;
      fresh         <= 1'b1;
      prev_red      <= 1'b0;
      phase_o       <= '0;
      phase_valid_o <= 1'b0;
      err_pulse_o   <= 1'b0;
      err_sticky_o  <= 1'b0;
      err_code_o    <= '0;
      cycle_done_o  <= 1'b0;
      cycle_count_o <= '0;
    end else begin
      state         <= nxt;
      dwell         <= nxt_dwell;
      fresh         <= 1'b0;
      prev_red      <= red_i;
      phase_o       <= nxt_ph;
      phase_valid_o <= (nxt != ST_SYNC);
      err_pulse_o   <= err;
      cycle_done_o  <= done;
      if (err) err_sticky_o <= 1'b1;
      if (err && err_code_o == ERR_NONE) err_code_o <= err_code;
      if (done) cycle_count_o <= cycle_count_o + 8'd1;
    end
  end

endmodule
